// File: rtl/seq_code_pkg.sv
// Shared definitions for the programmable code-sequence counter:
// end-of-range modes, the power-on table contents and the legacy code sequence.
package seq_code_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int unsigned LEGACY_LEN = 16;

  // Code sequence of the former fixed counter, used to seed the table in the field
  localparam logic [3:0] LEGACY_SEQ [LEGACY_LEN] = '{
    4'h5, 4'hC, 4'h0, 4'h8, 4'h6, 4'h8, 4'h5, 4'hF,
    4'h9, 4'hD, 4'h9, 4'hE, 4'hC, 4'h7, 4'hF, 4'hC
  };

  // Power-on table entry i: i mod 2^data_w
  function automatic logic [63:0] default_code(input int unsigned i,
                                               input int unsigned data_w);
    logic [63:0] mask;
    mask = (64'd1 << data_w) - 64'd1;
    return 64'(i) & mask;
  endfunction

endpackage

// File: rtl/seq_code_table.sv
// DEPTH x DATA_W sequence table: synchronous reset to default codes,
// synchronous write, one asynchronous read port.
module seq_code_table
  import seq_code_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [IDX_W-1:0]  WADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [IDX_W-1:0]  RADDR,
  output logic [DATA_W-1:0] RDATA
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset has priority: a write presented during reset is discarded
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= DATA_W'(default_code(i, DATA_W));
      end
    end else if (WE) begin
      mem[WADDR] <= WDATA;
    end
  end

  assign RDATA = mem[RADDR];

endmodule

// File: rtl/seq_code_counter.sv
// Up/down counter stepping an index through a programmable code table,
// with programmable active length, wrap/saturate ends and terminal-count pulse.
module seq_code_counter
  import seq_code_pkg::*;
#(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned RESET_IDX = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic              UP,
  input  logic              LOAD,
  input  logic [IDX_W-1:0]  DAT_I,
  input  logic [IDX_W-1:0]  LAST_I,
  input  logic              SAT_I,
  input  logic              WE,
  input  logic [IDX_W-1:0]  WADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] DATA_O,
  output logic [IDX_W-1:0]  IDX_O,
  output logic              TC_O
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic             tc_q;
  logic             tc_nxt;
  logic             sat;

  assign sat = (mode_e'(SAT_I) == MODE_SAT);

  // An index left above LAST_I by a range shrink counts as at-top going up
  // and clamps to LAST_I going down; it is not moved until the next step/load.
  always_comb begin
    idx_nxt = idx_q;
    tc_nxt  = 1'b0;
    if (LOAD) begin
      idx_nxt = (DAT_I > LAST_I) ? LAST_I : DAT_I;
    end else if (CE) begin
      if (UP) begin
        if (idx_q < LAST_I) begin
          idx_nxt = idx_q + IDX_W'(1);
        end else begin
          idx_nxt = sat ? LAST_I : '0;
          tc_nxt  = 1'b1;
        end
      end else begin
        if (idx_q == '0) begin
          idx_nxt = sat ? '0 : LAST_I;
          tc_nxt  = 1'b1;
        end else if (idx_q > LAST_I) begin
          idx_nxt = LAST_I;
        end else begin
          idx_nxt = idx_q - IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q <= IDX_W'(RESET_IDX);
      tc_q  <= 1'b0;
    end else begin
      idx_q <= idx_nxt;
      tc_q  <= tc_nxt;
    end
  end

  seq_code_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .CLK   (CLK),
    .RST   (RST),
    .WE    (WE),
    .WADDR (WADDR),
    .WDATA (WDATA),
    .RADDR (idx_q),
    .RDATA (DATA_O)
  );

  assign IDX_O = idx_q;
  assign TC_O  = tc_q;

endmodule

// File: tb/tb_seq_code_counter.sv
// Scoreboard bench for seq_code_counter: directed stimulus queues expected
// outputs, a monitor pops and compares one entry after every rising edge.
module tb_seq_code_counter;
  import seq_code_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, CE, UP, LOAD, SAT_I, WE;
  logic [3:0] DAT_I, LAST_I, WADDR, WDATA;
  logic [3:0] DATA_O, IDX_O;
  logic       TC_O;

  typedef struct {
    string      name;
    logic [2:0] m;     // check mask {idx, data, tc}
    logic [3:0] idx;
    logic [3:0] data;
    logic       tc;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  seq_code_counter #(
    .DATA_W    (4),
    .DEPTH     (16),
    .IDX_W     (4),
    .RESET_IDX (0)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .CE     (CE),
    .UP     (UP),
    .LOAD   (LOAD),
    .DAT_I  (DAT_I),
    .LAST_I (LAST_I),
    .SAT_I  (SAT_I),
    .WE     (WE),
    .WADDR  (WADDR),
    .WDATA  (WDATA),
    .DATA_O (DATA_O),
    .IDX_O  (IDX_O),
    .TC_O   (TC_O)
  );

  always #5 CLK = ~CLK;

  // Monitor: outputs are valid every cycle, so one expectation per rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.m[2]) begin
          n_vec++;
          if (IDX_O !== e.idx) begin
            n_miss++;
            $display("FAIL %s idx: got %h expected %h", e.name, IDX_O, e.idx);
          end
        end
        if (e.m[1]) begin
          n_vec++;
          if (DATA_O !== e.data) begin
            n_miss++;
            $display("FAIL %s data: got %h expected %h", e.name, DATA_O, e.data);
          end
        end
        if (e.m[0]) begin
          n_vec++;
          if (TC_O !== e.tc) begin
            n_miss++;
            $display("FAIL %s tc: got %b expected %b", e.name, TC_O, e.tc);
          end
        end
      end
    end
  end

  task automatic set(input logic rst, input logic ce, input logic up,
                     input logic load, input logic [3:0] dat);
    RST = rst; CE = ce; UP = up; LOAD = load; DAT_I = dat;
  endtask

  // Queue the expected result of the inputs currently driven, then advance one cycle
  task automatic expect_next(input string name, input logic [2:0] m,
                             input logic [3:0] idx, input logic [3:0] data,
                             input logic tc);
    exp_t e;
    e.name = name; e.m = m; e.idx = idx; e.data = data; e.tc = tc;
    q.push_back(e);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] k4;
    set(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    LAST_I = 4'hF; SAT_I = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0;
    @(negedge CLK);

    // Reset and default count through all 16 codes
    expect_next("reset", 3'b111, 4'h0, 4'h0, 1'b0);
    set(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int k = 1; k <= 16; k++) begin
      k4 = 4'(k);
      expect_next("default_count", 3'b111, k4, k4, (k == 16));
    end
    set(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    expect_next("default_idle", 3'b101, 4'h0, 4'h0, 1'b0);

    // Program legacy sequence, then count through it
    WE = 1'b1;
    for (int i = 0; i < 16; i++) begin
      WADDR = 4'(i); WDATA = LEGACY_SEQ[i];
      expect_next("legacy_write", 3'b111, 4'h0, 4'h5, 1'b0);
    end
    WE = 1'b0;
    set(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    expect_next("legacy_load", 3'b111, 4'h0, 4'h5, 1'b0);
    set(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int k = 1; k <= 16; k++) begin
      expect_next("legacy_count", 3'b111, 4'(k), LEGACY_SEQ[k % 16], (k == 16));
    end
    set(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      expect_next("legacy_hold", 3'b111, 4'h0, 4'h5, 1'b0);
    end

    // Saturation at both ends of 0..3
    SAT_I = 1'b1; LAST_I = 4'h3;
    set(1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    expect_next("sat_load", 3'b101, 4'h2, 4'h0, 1'b0);
    set(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    expect_next("sat_up", 3'b101, 4'h3, 4'h0, 1'b0);
    expect_next("sat_up", 3'b101, 4'h3, 4'h0, 1'b1);
    expect_next("sat_up", 3'b101, 4'h3, 4'h0, 1'b1);
    set(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    expect_next("sat_dn", 3'b101, 4'h2, 4'h0, 1'b0);
    expect_next("sat_dn", 3'b101, 4'h1, 4'h0, 1'b0);
    expect_next("sat_dn", 3'b101, 4'h0, 4'h0, 1'b0);
    expect_next("sat_dn", 3'b101, 4'h0, 4'h0, 1'b1);
    expect_next("sat_dn", 3'b101, 4'h0, 4'h0, 1'b1);

    // Load clamp, LOAD beats CE, then wrap from top
    LAST_I = 4'h5;
    set(1'b0, 1'b1, 1'b1, 1'b1, 4'h9);
    expect_next("load_clamp", 3'b101, 4'h5, 4'h0, 1'b0);
    SAT_I = 1'b0;
    set(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    expect_next("wrap_top", 3'b111, 4'h0, 4'h5, 1'b1);

    // Range shrink below the current index
    LAST_I = 4'hF;
    set(1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
    expect_next("shrink_load", 3'b101, 4'hA, 4'h0, 1'b0);
    LAST_I = 4'h4;
    set(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    expect_next("shrink_hold", 3'b101, 4'hA, 4'h0, 1'b0);
    set(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    expect_next("shrink_dn", 3'b101, 4'h4, 4'h0, 1'b0);
    LAST_I = 4'hF;
    set(1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
    expect_next("shrink_load2", 3'b101, 4'hA, 4'h0, 1'b0);
    LAST_I = 4'h4;
    set(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    expect_next("shrink_up_wrap", 3'b101, 4'h0, 4'h0, 1'b1);
    LAST_I = 4'hF;
    set(1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
    expect_next("shrink_load3", 3'b101, 4'hA, 4'h0, 1'b0);
    LAST_I = 4'h4; SAT_I = 1'b1;
    set(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    expect_next("shrink_up_sat", 3'b101, 4'h4, 4'h0, 1'b1);

    // Single-entry range
    LAST_I = 4'h0; SAT_I = 1'b0;
    set(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    expect_next("single_load", 3'b101, 4'h0, 4'h0, 1'b0);
    set(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    expect_next("single_up", 3'b101, 4'h0, 4'h0, 1'b1);
    set(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    expect_next("single_dn", 3'b101, 4'h0, 4'h0, 1'b1);

    // Write at the current index, write with step, reset beating write
    LAST_I = 4'hF;
    set(1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    expect_next("wr_load", 3'b111, 4'h2, 4'h0, 1'b0);
    set(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    WE = 1'b1; WADDR = 4'h2; WDATA = 4'hA;
    expect_next("wr_same_idx", 3'b111, 4'h2, 4'hA, 1'b0);
    set(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    WADDR = 4'h3; WDATA = 4'hB;
    expect_next("wr_with_step", 3'b111, 4'h3, 4'hB, 1'b0);
    set(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    WADDR = 4'h2; WDATA = 4'h7;
    expect_next("rst_over_we", 3'b111, 4'h0, 4'h0, 1'b0);
    WE = 1'b0;
    set(1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    expect_next("rst_tbl2", 3'b111, 4'h2, 4'h2, 1'b0);
    set(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    expect_next("rst_tbl3", 3'b111, 4'h3, 4'h3, 1'b0);

    set(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    @(negedge CLK);
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
